// File: rtl/exu_seq_pkg.sv
// -----------------------------------------------------------------------------
// exu_seq_pkg
// Shared definitions for the EXU multicycle sequencer:
//   - RV32 major opcode constants used to classify the retiring instruction
//   - state_e    : sequencer FSM states
//   - exu_req_t  : decoded instruction bundle (fields + operands + pc + imm)
//   - br_target  : wrap-around branch target adder
// -----------------------------------------------------------------------------
package exu_seq_pkg;

    localparam int EXU_XLEN = 32;
    // Wide enough for the largest legal latency preload (ALU_LAT-1 = 14).
    localparam int CNT_W    = 4;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_ARITH  = 7'b0010011;
    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic [EXU_XLEN-1:0] op1;
        logic [EXU_XLEN-1:0] op2;
        logic [EXU_XLEN-1:0] pc;
        logic [EXU_XLEN-1:0] imm;
    } exu_req_t;

    // pc + imm, truncated to the datapath width (wraps mod 2^XLEN).
    function automatic logic [EXU_XLEN-1:0] br_target(input logic [EXU_XLEN-1:0] pc,
                                                      input logic [EXU_XLEN-1:0] imm);
        return pc + imm;
    endfunction

endpackage

// File: rtl/exu_seq_if.sv
// -----------------------------------------------------------------------------
// exu_seq_if
// Bundles the three sequencer-facing buses:
//   in_*  : IDU -> sequencer instruction handshake (valid/ready)
//   exu_* : sequencer -> EXU operands, plus exu_res coming back
//   out_* : sequencer -> LSU/WBU result handshake (valid/ready)
// Modports:
//   slave  : the sequencer (accepts instructions, drives EXU and result)
//   master : the surrounding core / testbench
// -----------------------------------------------------------------------------
interface exu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_func3;
    logic [6:0]      in_func7;
    logic [XLEN-1:0] in_op1;
    logic [XLEN-1:0] in_op2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;

    logic [XLEN-1:0] exu_op1;
    logic [XLEN-1:0] exu_op2;
    logic [6:0]      exu_opcode;
    logic [2:0]      exu_func3;
    logic [6:0]      exu_func7;
    logic [XLEN-1:0] exu_res;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [6:0]      out_opcode;
    logic            out_br_taken;
    logic [XLEN-1:0] out_br_target;

    modport slave (
        input  in_valid, in_opcode, in_func3, in_func7, in_op1, in_op2, in_pc, in_imm,
        output in_ready,
        output exu_op1, exu_op2, exu_opcode, exu_func3, exu_func7,
        input  exu_res,
        output out_valid, out_res, out_opcode, out_br_taken, out_br_target,
        input  out_ready
    );

    modport master (
        output in_valid, in_opcode, in_func3, in_func7, in_op1, in_op2, in_pc, in_imm,
        input  in_ready,
        input  exu_op1, exu_op2, exu_opcode, exu_func3, exu_func7,
        output exu_res,
        input  out_valid, out_res, out_opcode, out_br_taken, out_br_target,
        output out_ready
    );

endinterface

// File: rtl/exu_seq_cnt.sv
// -----------------------------------------------------------------------------
// exu_seq_cnt
// Loadable down-counter with zero flag, used to time the ALU latency.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (count -> 0)
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : preload value
//   dec_i        : decrement by one; saturates at zero
//   zero_o       : count is zero
// -----------------------------------------------------------------------------
module exu_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exu_seq.sv
// -----------------------------------------------------------------------------
// exu_seq
// Multicycle sequencer around the EXU/ALU datapath. Accepts one decoded
// instruction, holds its operands on the EXU for ALU_LAT cycles, captures the
// result and presents it (with branch decision and pc+imm target) downstream.
//
// Parameters:
//   XLEN    : datapath width (must match exu_seq_pkg::EXU_XLEN)
//   ALU_LAT : cycles from operand drive to valid exu_res, 1..15
// Ports:
//   clk     : core clock
//   rst_n   : asynchronous active-low reset
//   flush   : kill the in-flight instruction; wins over every other event
//   bus     : exu_seq_if.slave (in_*, exu_*, out_* buses)
//   busy    : state != IDLE
//   perf_busy_cyc / perf_stall_cyc / perf_retired : only when the
//             EXU_SEQ_PERF_EN macro is defined
// -----------------------------------------------------------------------------
module exu_seq
    import exu_seq_pkg::*;
#(
    parameter int XLEN    = EXU_XLEN,
    parameter int ALU_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    exu_seq_if.slave     bus,
    output logic         busy
`ifdef EXU_SEQ_PERF_EN
    ,
    output logic [31:0]  perf_busy_cyc,
    output logic [31:0]  perf_stall_cyc,
    output logic [31:0]  perf_retired
`endif
);

    if ((ALU_LAT < 1) || (ALU_LAT > 15)) begin : g_bad_lat
        $error("exu_seq: ALU_LAT=%0d outside legal range 1..15", ALU_LAT);
    end
    if (XLEN != EXU_XLEN) begin : g_bad_xlen
        $error("exu_seq: XLEN=%0d differs from exu_seq_pkg::EXU_XLEN", XLEN);
    end

    // The counter is preloaded with ALU_LAT-1 on accept, so the capture edge
    // lands exactly ALU_LAT edges after the accept edge.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

    state_e          state_q, state_d;
    exu_req_t        req_q, req_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            br_taken_q, br_taken_d;

    logic            in_ready_w;
    logic            accept;
    logic            cnt_dec;
    logic            cnt_zero;

    exu_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        res_d      = res_q;
        br_taken_d = br_taken_q;
        target_d   = target_q;
        cnt_dec    = 1'b0;

        // DONE with out_ready retires this edge, so a new accept can share it.
        in_ready_w = rst_n & ~flush &
                     ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
        accept     = in_ready_w & bus.in_valid;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_zero) begin
                    if (!flush) begin
                        res_d      = bus.exu_res;
                        br_taken_d = (req_q.opcode == OPCODE_BRANCH) & bus.exu_res[0];
                        target_d   = br_target(req_q.pc, req_q.imm);
                    end
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = accept ? EXEC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            req_d.opcode = bus.in_opcode;
            req_d.func3  = bus.in_func3;
            req_d.func7  = bus.in_func7;
            req_d.op1    = bus.in_op1;
            req_d.op2    = bus.in_op2;
            req_d.pc     = bus.in_pc;
            req_d.imm    = bus.in_imm;
        end

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            res_q      <= '0;
            br_taken_q <= 1'b0;
            target_q   <= '0;
        end else begin
            req_q      <= req_d;
            res_q      <= res_d;
            br_taken_q <= br_taken_d;
            target_q   <= target_d;
        end
    end

    assign bus.in_ready      = in_ready_w;
    assign bus.exu_op1       = req_q.op1;
    assign bus.exu_op2       = req_q.op2;
    assign bus.exu_opcode    = req_q.opcode;
    assign bus.exu_func3     = req_q.func3;
    assign bus.exu_func7     = req_q.func7;
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_res       = res_q;
    assign bus.out_opcode    = req_q.opcode;
    assign bus.out_br_taken  = br_taken_q;
    assign bus.out_br_target = target_q;
    assign busy              = (state_q != IDLE);

`ifdef EXU_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q, perf_ret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
            perf_ret_q   <= '0;
        end else begin
            if (state_q == EXEC) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((state_q == DONE) && !bus.out_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if ((state_q == DONE) && bus.out_ready) begin
                perf_ret_q <= perf_ret_q + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_stall_cyc = perf_stall_q;
    assign perf_retired   = perf_ret_q;
`endif

endmodule

// File: doc/exu_seq.md
Name: exu_seq

Overview:
- Multicycle sequencer wrapped around the EXU/ALU datapath in the multicycle-with-delay core.
- Accepts one decoded instruction from IDU over a valid/ready handshake and registers the operands.
- Holds the operands stable on the EXU inputs for a fixed ALU latency, then captures the result.
- Presents result, branch decision and branch target to LSU/WBU over a second valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- ALU_LAT, 2, cycles from operand drive to a valid alu_res; legal range 1..15; elaboration error outside it.

Ports:
- clk  in  1  core clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill in-flight instruction (redirect/trap).
- in_valid  in  1  IDU offers an instruction.
- in_ready  out  1  sequencer can accept.
- in_opcode/in_func3/in_func7  in  7/3/7  decoded fields.
- in_op1, in_op2, in_pc, in_imm  in  XLEN each  operands, PC, immediate.
- exu_op1, exu_op2  out  XLEN  registered operands to EXU.
- exu_opcode/exu_func3/exu_func7  out  7/3/7  registered fields to EXU.
- exu_res  in  XLEN  EXU result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_res  out  XLEN  captured result.
- out_opcode  out  7  opcode of the retiring instruction.
- out_br_taken  out  1  branch decision.
- out_br_target  out  XLEN  pc+imm.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, EXEC, DONE (2-bit enum).
- Reset (async, rst_n=0): state=IDLE; cnt=0; all operand/field/result registers=0; out_valid=0; busy=0; in_ready=1 once rst_n deasserts.
- in_ready = (state==IDLE) | (state==DONE & out_ready), gated low by flush.
- Accept when in_valid & in_ready:
  - latch opcode, func3, func7, op1, op2, pc, imm;
  - cnt <= ALU_LAT-1;
  - state -> EXEC.
- EXEC:
  - exu_* outputs are driven only from the latched registers and are stable every EXEC cycle;
  - cnt decrements each cycle;
  - on the cycle cnt==0: res_q <= exu_res; br_taken_q <= (opcode==OPCODE_BRANCH) & exu_res[0]; target_q <= pc+imm (mod 2^XLEN); state -> DONE.
- Latency: with ALU_LAT=N, out_valid rises N cycles after the accept edge.
- DONE:
  - out_valid=1; out_* driven from registers and held stable while out_ready=0 (no combinational path from exu_res to out_*);
  - out_ready=1, no new in_valid: state -> IDLE;
  - out_ready=1 with in_valid: retire and accept on the same edge, state -> EXEC (back-to-back, one idle bubble avoided).
- out_br_taken is 0 for every non-branch opcode.
- flush (any state) wins over all other events: state -> IDLE next edge; out_valid=0 next cycle; no accept that cycle even if in_valid=1; result dropped.
- out_valid is never asserted while state != DONE.
- Reset asserted mid-EXEC: immediate return to the reset values; the pending result is lost.

Optional Feature:
- Macro EXU_SEQ_PERF_EN.
- Defined:
  - adds outputs perf_busy_cyc[31:0] (increments each cycle state==EXEC), perf_stall_cyc[31:0] (increments each cycle DONE & !out_ready) and perf_retired[31:0] (increments on each out handshake);
  - counters wrap at 2^32, reset to 0, are unaffected by flush.
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared package: OPCODE_* constants (BRANCH, ARITH, R, LUI, AUIPC, LOAD, STORE), the state enum typedef, and an exu_req_t struct (opcode, func3, func7, op1, op2, pc, imm) used for both the input bundle and the latch register.
- One sub-module, exu_seq_cnt: loadable down-counter with zero flag, reused for the latency countdown.

Test Plan:
- ALU_LAT=2; ARITH ADD, op1=5, op2=7, EXU model returns sum after 2 cycles -> out_valid 2 cycles after accept, out_res=12, out_br_taken=0.
- BRANCH, pc=0x8000_0000, imm=0x10, EXU returns 1 -> out_br_taken=1, out_br_target=0x8000_0010; with EXU returning 0 -> out_br_taken=0.
- out_ready held low 5 cycles in DONE -> out_valid stays 1, out_res stable, in_ready=0; then out_ready=1 with in_valid=1 -> retire and accept on the same edge.
- flush asserted in EXEC (cnt=1) together with in_valid=1 -> IDLE next cycle, no out_valid pulse, no accept.
- rst_n pulsed low asynchronously mid-EXEC -> all outputs reach reset values without waiting for a clock edge; in_ready=1 after release.
- pc=0xFFFF_FFF0, imm=0x20 -> out_br_target=0x0000_0010 (wrap). With EXU_SEQ_PERF_EN defined, 3 back-to-back instructions at ALU_LAT=2 -> perf_retired=3, perf_busy_cyc=6.
